// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: FSM state encoding and
// the default operand width.
package hilo_mult_unit_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative radix-2 shift-add multiplier feeding the HI/LO
// register pair, with mthi/mtlo write ports for software access.
// Optional macro MULT_SIGNED_EN: when defined, is_signed selects a signed
// multiply (magnitudes multiplied, result negated when the signs differ);
// when undefined every multiply is unsigned and the sign logic is absent.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    iter_cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [2*DATA_W-1:0] acc_sum;
    logic [2*DATA_W-1:0] product;
    logic                last_iter;

`ifdef MULT_SIGNED_EN
    logic start_neg;
    logic neg_result;
`else
    logic is_signed_unused;
    assign is_signed_unused = is_signed;
`endif

    assign last_iter = (iter_cnt == LAST_ITER);

    // Operand conditioning: reduce signed operands to unsigned magnitudes.
    always_comb begin
        mag_a = ReadData1;
        mag_b = ReadData2;
`ifdef MULT_SIGNED_EN
        start_neg = is_signed & (ReadData1[DATA_W-1] ^ ReadData2[DATA_W-1]);
        if (is_signed && ReadData1[DATA_W-1]) begin
            mag_a = -ReadData1;
        end
        if (is_signed && ReadData2[DATA_W-1]) begin
            mag_b = -ReadData2;
        end
`endif
    end

    // One shift-add step and the final (optionally negated) product.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
`ifdef MULT_SIGNED_EN
        product = neg_result ? -acc_sum : acc_sum;
`else
        product = acc_sum;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, product load and mthi/mtlo writes.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            HI       <= '0;
            LO       <= '0;
`ifdef MULT_SIGNED_EN
            neg_result <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        acc      <= '0;
                        mcand    <= {{DATA_W{1'b0}}, mag_a};
                        mplier   <= mag_b;
`ifdef MULT_SIGNED_EN
                        neg_result <= start_neg;
`endif
                    end else begin
                        if (hi_we) begin
                            HI <= wdata;
                        end
                        if (lo_we) begin
                            LO <= wdata;
                        end
                    end
                end
                CALC: begin
                    acc      <= acc_sum;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (last_iter) begin
                        HI <= product[2*DATA_W-1:DATA_W];
                        LO <= product[DATA_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard testbench for hilo_mult_unit: stimulus pushes expected products
// and done cycles, a monitor pops and compares on every done pulse.
module tb_hilo_mult_unit;

    localparam int DATA_W = 32;

    logic              clk;
    logic              Reset;
    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [2*DATA_W-1:0] exp_q[$];
    int                  cyc_q[$];

    logic [DATA_W-1:0] model_hi = '0;
    logic [DATA_W-1:0] model_lo = '0;
    logic [DATA_W-1:0] prev_hi  = '0;
    logic [DATA_W-1:0] prev_lo  = '0;

    hilo_mult_unit #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .is_signed (is_signed),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Reference product straight from integer arithmetic.
    function automatic logic [2*DATA_W-1:0] refProduct(logic [DATA_W-1:0] a,
                                                       logic [DATA_W-1:0] b,
                                                       logic sgn);
        logic use_signed;
        longint sp;
        use_signed = sgn;
`ifndef MULT_SIGNED_EN
        use_signed = 1'b0;
`endif
        if (use_signed) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (Reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                checkOutput("product", {HI, LO}, exp_q.pop_front());
                checkOutput("latency", 64'(cyc), 64'(cyc_q.pop_front()));
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Issue one multiply at a negedge; leaves start low one cycle later.
    task automatic applyStimulus(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                                 logic sgn, bit expect_result);
        logic [2*DATA_W-1:0] p;
        waitIdle();
        start     = 1'b1;
        is_signed = sgn;
        ReadData1 = a;
        ReadData2 = b;
        prev_hi   = model_hi;
        prev_lo   = model_lo;
        if (expect_result) begin
            p = refProduct(a, b, sgn);
            exp_q.push_back(p);
            cyc_q.push_back(cyc + DATA_W + 1);
            model_hi = p[63:32];
            model_lo = p[31:0];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] ra, rb;
        Reset = 1'b0; start = 1'b0; is_signed = 1'b0;
        ReadData1 = '0; ReadData2 = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        @(negedge clk);
        Reset = 1'b1;

        // First start right after reset release, then the directed corners.
        applyStimulus(32'd7, 32'd6, 1'b0, 1'b1);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        waitDrain();
        checkOutput("hold_lo_42", 64'(LO), 64'h2A);
        applyStimulus(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b1);
        waitDrain();

        // mthi/mtlo in IDLE are visible the next cycle.
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        model_hi = 32'h12345678;
        checkOutput("mthi", 64'(HI), 64'h12345678);
        lo_we = 1'b1; wdata = 32'h0BADF00D;
        @(negedge clk);
        lo_we = 1'b0;
        model_lo = 32'h0BADF00D;
        checkOutput("mtlo", 64'(LO), 64'h0BADF00D);

        // start together with mthi: the write is dropped.
        hi_we = 1'b1; wdata = 32'hCAFEF00D;
        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1);
        hi_we = 1'b0;
        checkOutput("start_beats_mthi", 64'(HI), 64'(prev_hi));

        // Second start and mtlo while busy are both ignored.
        repeat (4) @(negedge clk);
        start = 1'b1; ReadData1 = 32'd99; ReadData2 = 32'd77; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        checkOutput("mtlo_busy_lo", 64'(LO), 64'(prev_lo));
        checkOutput("busy_mid_op", 64'(busy), 64'd1);
        waitDrain();
        checkOutput("no_requeue", 64'(busy), 64'd0);

        // Reset during CALC aborts the multiply with no done and clears HI/LO.
        applyStimulus(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        model_hi = '0; model_lo = '0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_hi", 64'(HI), 64'd0);
        checkOutput("abort_lo", 64'(LO), 64'd0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("abort_hold_lo", 64'(LO), 64'd0);
        applyStimulus(32'd2, 32'd3, 1'b0, 1'b1);
        waitDrain();
        checkOutput("fresh_lo", 64'(LO), 64'd6);

        // Randomized operations with occasional corner operands.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'd0;
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitDrain();
        checkOutput("final_hi", 64'(HI), 64'(model_hi));
        checkOutput("final_lo", 64'(LO), 64'(model_lo));
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width; HI and LO are each DATA_W bits.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply of ReadData1 by ReadData2; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = signed multiply (mult), 0 = unsigned multiply (multu); sampled with start.
REQ-006 ReadData1  input  DATA_W  multiplicand from the register file port 1.
REQ-007 ReadData2  input  DATA_W  multiplier from the register file port 2.
REQ-008 hi_we  input  1  mthi strobe: write wdata into HI.
REQ-009 lo_we  input  1  mtlo strobe: write wdata into LO.
REQ-010 wdata  input  DATA_W  data for mthi/mtlo.
REQ-011 busy  output  1  high while in CALC or DONE.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new product.
REQ-013 HI  output  DATA_W  upper product half (mfhi source).
REQ-014 LO  output  DATA_W  lower product half (mflo source).

Function
REQ-015 FSM states: IDLE, CALC, DONE; transitions IDLE->CALC on start; CALC->DONE after DATA_W iterations; DONE->IDLE unconditionally.
REQ-016 On the start edge (N): latch operand magnitudes, sign flag (is_signed & (a_msb ^ b_msb)), clear 2*DATA_W accumulator, load iteration counter with 0.
REQ-017 CALC: radix-2 shift-add, one multiplier bit per cycle (LSB first); DATA_W cycles (edges N+1..N+DATA_W).
REQ-018 At edge N+DATA_W: HI/LO loaded with the product (negated two's complement of the full 2*DATA_W value when the sign flag is set); state -> DONE.
REQ-019 done = 1 for exactly the cycle after edge N+DATA_W; start-to-result latency DATA_W+1 cycles (33 for DATA_W=32).
REQ-020 Magnitude of -2^(DATA_W-1) is 2^(DATA_W-1), held unsigned in DATA_W bits; no overflow.
REQ-021 start while busy: ignored, no queuing, in-flight operation unaffected.
REQ-022 hi_we/lo_we while busy: ignored; in IDLE they write on the edge and are visible next cycle.
REQ-023 start together with hi_we or lo_we in IDLE: start wins, write discarded.
REQ-024 HI/LO hold their value at all times except REQ-018 and REQ-022 updates.

Reset
REQ-025 Reset low: immediately state IDLE, busy=0, done=0, HI=0, LO=0, counter and accumulator cleared.
REQ-026 Reset mid-operation aborts the multiply; no partial result reaches HI/LO.
REQ-027 First start is accepted on the first rising edge after Reset deasserts.

Configuration
REQ-028 Macro MULT_SIGNED_EN: defined -> is_signed honoured per REQ-016/018; undefined -> is_signed ignored, every operation unsigned, sign-correction logic absent.

Structure
REQ-029 Shared package holds the FSM state encoding (IDLE/CALC/DONE) and the DATA_W default constant.
REQ-030 Single module; no sub-module (datapath and FSM share the iteration counter).

Verification
REQ-031 Unsigned 7 x 6: done at cycle 33 after start, HI=0x00000000, LO=0x0000002A.
REQ-032 Signed -3 x 5 (0xFFFFFFFD, 0x00000005, is_signed=1): HI=0xFFFFFFFF, LO=0xFFFFFFF1; without MULT_SIGNED_EN: HI=0x00000004, LO=0xFFFFFFF1.
REQ-033 Unsigned 0xFFFFFFFF x 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001; signed 0x80000000 x 0x80000000: HI=0x40000000, LO=0.
REQ-034 Second start 5 cycles into an operation with different operands: ignored, single done, first product only.
REQ-035 Reset pulsed at cycle 10 of CALC: busy=0, HI=LO=0, no done pulse; fresh 2 x 3 then gives LO=6.
REQ-036 mthi 0x12345678 in IDLE -> HI=0x12345678 next cycle; mtlo while busy -> LO unchanged until product load.
